// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways, LRU) with a built-in block-refill FSM.
// Latency: hit -> respValid the cycle after acceptance; miss -> 3 cycles minimum with zero-wait memory.
// Backpressure: reqReady low while flushing or refilling; no response backpressure (respValid is a pulse).
// Ports: clkIn/resetIn (async, active-low); reqValid/reqAddr/reqReady fetch side; flushIn invalidates all;
//        respValid/respInstr response; memReq*/memResp* line refill; hitCount/missCount wrap at 2^32.
module icache_assoc #(
  parameter int BLOCK_WIDTH = 4,
  parameter int SET_WIDTH   = 6,
  parameter int WAYS        = 2
) (
  input  logic                      clkIn,
  input  logic                      resetIn,
  input  logic                      reqValid,
  input  logic [31:0]               reqAddr,
  output logic                      reqReady,
  input  logic                      flushIn,
  output logic                      respValid,
  output logic [31:0]               respInstr,
  output logic                      memReqValid,
  output logic [32-BLOCK_WIDTH-1:0] memReqAddr,
  input  logic                      memReqReady,
  input  logic                      memRespValid,
  input  logic [8*2**BLOCK_WIDTH-1:0] memRespData,
  output logic [31:0]               hitCount,
  output logic [31:0]               missCount
);

  localparam int LINE_W = 8 << BLOCK_WIDTH;
  localparam int SETS   = 1 << SET_WIDTH;
  localparam int TAG_W  = 32 - BLOCK_WIDTH - SET_WIDTH;
  localparam int WSEL_W = BLOCK_WIDTH - 2;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] RESPOND  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [31:2]       addr_q, addr_d;
  logic              pend_q, pend_d;
  logic              resp_vld_q, resp_vld_d;
  logic [31:0]       resp_instr_q, resp_instr_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   valid_d [WAYS];
  logic [SETS-1:0]   lru_q, lru_d;

  // Line storage carries no reset: a line is only ever read when its valid bit is set.
  logic [LINE_W-1:0] data_q [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q  [WAYS][SETS];

  logic [SET_WIDTH-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]     req_tag, fill_tag;
  logic [WSEL_W-1:0]    req_wsel, fill_wsel;
  logic                 hit_any, hit_way, victim, fill_we;
  logic [31:0]          hit_word;
  logic                 unused_addr;

  assign unused_addr = ^reqAddr[1:0];

  assign req_idx   = reqAddr[BLOCK_WIDTH +: SET_WIDTH];
  assign req_tag   = reqAddr[31 -: TAG_W];
  assign req_wsel  = reqAddr[2 +: WSEL_W];
  assign fill_idx  = addr_q[BLOCK_WIDTH +: SET_WIDTH];
  assign fill_tag  = addr_q[31 -: TAG_W];
  assign fill_wsel = addr_q[2 +: WSEL_W];

  assign reqReady    = (state_q == IDLE) && !flushIn;
  assign memReqValid = (state_q == MEM_REQ);
  assign memReqAddr  = addr_q[31:BLOCK_WIDTH];
  assign respValid   = resp_vld_q;
  assign respInstr   = resp_instr_q;
  assign hitCount    = hit_cnt_q;
  assign missCount   = miss_cnt_q;

  // Combinational tag compare on the live request address.
  always_comb begin
    hit_any = 1'b0;
    hit_way = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = w[0];
      end
    end
    hit_word = data_q[hit_way][req_idx][{req_wsel, 5'b0} +: 32];
  end

  // Victim: fill an empty way first (way 0 before way 1), otherwise evict the LRU way.
  always_comb begin
    victim = 1'b0;
    if (WAYS > 1) begin
      if (!valid_q[0][fill_idx])             victim = 1'b0;
      else if (!valid_q[WAYS-1][fill_idx])   victim = 1'b1;
      else                                   victim = lru_q[fill_idx];
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pend_d       = pend_q;
    resp_vld_d   = 1'b0;
    resp_instr_d = resp_instr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    valid_d      = valid_q;
    lru_d        = lru_q;
    fill_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flushIn) begin
          for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
        end else if (reqValid) begin
          if (hit_any) begin
            resp_vld_d       = 1'b1;
            resp_instr_d     = hit_word;
            lru_d[req_idx]   = ~hit_way;
            hit_cnt_d        = hit_cnt_q + 32'd1;
          end else begin
            addr_d     = reqAddr[31:2];
            miss_cnt_d = miss_cnt_q + 32'd1;
            state_d    = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        if (flushIn) pend_d = 1'b1;
        if (memReqReady) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (flushIn) pend_d = 1'b1;
        if (memRespValid) begin
          fill_we                   = 1'b1;
          valid_d[victim][fill_idx] = 1'b1;
          lru_d[fill_idx]           = ~victim;
          resp_vld_d                = 1'b1;
          resp_instr_d              = memRespData[{fill_wsel, 5'b0} +: 32];
          state_d                   = RESPOND;
        end
      end
      default: begin
        // RESPOND: a flush seen during the refill takes effect as we return to IDLE.
        state_d = IDLE;
        if (pend_q || flushIn) begin
          for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
          pend_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      resp_vld_q   <= 1'b0;
      resp_instr_q <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      lru_q        <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pend_q       <= pend_d;
      resp_vld_q   <= resp_vld_d;
      resp_instr_q <= resp_instr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      lru_q        <= lru_d;
      valid_q      <= valid_d;
    end
  end

  // fill_we is only raised in MEM_WAIT, so a reset mid-refill can never write a line.
  always_ff @(posedge clkIn) begin
    if (fill_we) begin
      data_q[victim][fill_idx] <= memRespData;
      tag_q[victim][fill_idx]  <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios plus randomized fetch traffic against an LRU-queue model.
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge or 1ns after a drive.
// Backpressure: bench plays the memory and controls memReqReady / memRespValid timing explicitly.
module tb_icache_assoc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetIn;
  logic         reqValid, reqReady, flushIn, respValid, memReqValid, memReqReady, memRespValid;
  logic [31:0]  reqAddr, respInstr, hitCount, missCount;
  logic [27:0]  memReqAddr;
  logic [127:0] memRespData;

  logic         reqValid_1, reqReady_1, respValid_1, memReqValid_1, memReqReady_1, memRespValid_1;
  logic [31:0]  reqAddr_1, respInstr_1, hitCount_1, missCount_1;
  logic [27:0]  memReqAddr_1;
  logic [127:0] memRespData_1;

  icache_assoc #(.BLOCK_WIDTH(4), .SET_WIDTH(6), .WAYS(2)) dut (
    .clkIn(clk), .resetIn(resetIn), .reqValid(reqValid), .reqAddr(reqAddr), .reqReady(reqReady),
    .flushIn(flushIn), .respValid(respValid), .respInstr(respInstr), .memReqValid(memReqValid),
    .memReqAddr(memReqAddr), .memReqReady(memReqReady), .memRespValid(memRespValid),
    .memRespData(memRespData), .hitCount(hitCount), .missCount(missCount)
  );

  icache_assoc #(.BLOCK_WIDTH(4), .SET_WIDTH(6), .WAYS(1)) dut1 (
    .clkIn(clk), .resetIn(resetIn), .reqValid(reqValid_1), .reqAddr(reqAddr_1), .reqReady(reqReady_1),
    .flushIn(1'b0), .respValid(respValid_1), .respInstr(respInstr_1), .memReqValid(memReqValid_1),
    .memReqAddr(memReqAddr_1), .memReqReady(memReqReady_1), .memRespValid(memRespValid_1),
    .memRespData(memRespData_1), .hitCount(hitCount_1), .missCount(missCount_1)
  );

  int n_vec = 0;
  int n_err = 0;
  bit last_obs_hit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each set is a recency-ordered list of resident line addresses (front = most recent).
  logic [27:0] m_set [64][$];
  logic [31:0] m_hits, m_miss;

  function automatic logic [31:0] mem_word(input logic [27:0] line, input int k);
    if (line == 28'h100) return 32'h11 * 32'(k + 1);
    return (32'(line) * 32'h9E3779B1) ^ (32'h5BD1E995 * 32'(k + 1));
  endfunction

  function automatic logic [127:0] line_data(input logic [27:0] line);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) d[32*k +: 32] = mem_word(line, k);
    return d;
  endfunction

  function automatic bit m_lookup(input logic [27:0] line);
    int s;
    s = int'(line[5:0]);
    for (int i = 0; i < m_set[s].size(); i++) begin
      if (m_set[s][i] == line) begin
        m_set[s].delete(i);
        m_set[s].push_front(line);
        return 1'b1;
      end
    end
    m_set[s].push_front(line);
    if (m_set[s].size() > 2) void'(m_set[s].pop_back());
    return 1'b0;
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < 64; s++) m_set[s].delete();
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus tasks (called on a falling edge) ----------------
  task automatic fetch(input logic [31:0] addr, input int stall, input int dly, input bit flush_w);
    logic [27:0] line;
    logic [31:0] exp_w;
    bit          exp_hit;
    line    = addr[31:4];
    exp_w   = mem_word(line, int'(addr[3:2]));
    exp_hit = m_lookup(line);
    if (exp_hit) m_hits++; else m_miss++;
    reqValid = 1'b1; reqAddr = addr;
    #1 chk("req_ready", reqReady, 1);
    @(negedge clk);
    reqValid = 1'b0; reqAddr = $urandom;
    last_obs_hit = respValid;
    if (exp_hit) begin
      chk("hit_vld", respValid, 1);
      chk("hit_instr", respInstr, exp_w);
      chk("hit_cnt", hitCount, m_hits);
      chk("hit_nomem", memReqValid, 0);
    end else begin
      chk("miss_memreq", memReqValid, 1);
      chk("miss_addr", memReqAddr, line);
      chk("miss_cnt", missCount, m_miss);
      chk("miss_noresp", respValid, 0);
      for (int s = 0; s < stall; s++) begin
        memReqReady = 1'b0;
        @(negedge clk);
        chk("stall_vld", memReqValid, 1);
        chk("stall_addr", memReqAddr, line);
        chk("stall_rdy", reqReady, 0);
      end
      memReqReady = 1'b1;
      @(negedge clk);
      memReqReady = 1'b0;
      chk("wait_memreq_low", memReqValid, 0);
      chk("wait_rdy", reqReady, 0);
      for (int d = 0; d < dly; d++) begin
        memRespData = rnd_line();
        flushIn = flush_w && (d == 0);
        @(negedge clk);
        flushIn = 1'b0;
        chk("wait_noresp", respValid, 0);
      end
      if (flush_w && dly == 0) flushIn = 1'b1;
      memRespValid = 1'b1; memRespData = line_data(line);
      @(negedge clk);
      memRespValid = 1'b0; flushIn = 1'b0; memRespData = rnd_line();
      chk("fill_vld", respValid, 1);
      chk("fill_instr", respInstr, exp_w);
      chk("respond_rdy", reqReady, 0);
      if (flush_w) m_clear();
      @(negedge clk);
      chk("resp_pulse", respValid, 0);
      chk("idle_rdy", reqReady, 1);
    end
  endtask

  task automatic do_flush();
    flushIn = 1'b1;
    #1 chk("flush_rdy", reqReady, 0);
    @(negedge clk);
    flushIn = 1'b0;
    m_clear();
  endtask

  task automatic flush_req(input logic [31:0] addr);
    flushIn = 1'b1; reqValid = 1'b1; reqAddr = addr;
    #1 chk("flush_blocks_req", reqReady, 0);
    @(negedge clk);
    flushIn = 1'b0; reqValid = 1'b0;
    chk("flush_no_accept", memReqValid, 0);
    chk("flush_no_resp", respValid, 0);
    m_clear();
    fetch(addr, 0, 0, 0);
  endtask

  task automatic spurious();
    memRespValid = 1'b1; memRespData = rnd_line();
    @(negedge clk);
    memRespValid = 1'b0;
    chk("spur_resp", respValid, 0);
    chk("spur_memreq", memReqValid, 0);
    chk("spur_rdy", reqReady, 1);
    chk("spur_hits", hitCount, m_hits);
    chk("spur_miss", missCount, m_miss);
  endtask

  task automatic fetch1(input logic [31:0] addr, input bit exp_hit, input string tag);
    logic [27:0] line;
    line = addr[31:4];
    reqValid_1 = 1'b1; reqAddr_1 = addr;
    @(negedge clk);
    reqValid_1 = 1'b0;
    chk({tag, "_hit"}, respValid_1, exp_hit);
    if (!exp_hit) begin
      chk({tag, "_addr"}, memReqAddr_1, line);
      memReqReady_1 = 1'b1;
      @(negedge clk);
      memReqReady_1 = 1'b0; memRespValid_1 = 1'b1; memRespData_1 = line_data(line);
      @(negedge clk);
      memRespValid_1 = 1'b0;
      chk({tag, "_vld"}, respValid_1, 1);
    end
    chk({tag, "_instr"}, respInstr_1, mem_word(line, int'(addr[3:2])));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          op;
    resetIn = 1'b0; reqValid = 1'b0; reqAddr = '0; flushIn = 1'b0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0;
    reqValid_1 = 1'b0; reqAddr_1 = '0; memReqReady_1 = 1'b0; memRespValid_1 = 1'b0; memRespData_1 = '0;
    m_hits = 0; m_miss = 0; m_clear();
    repeat (3) @(negedge clk);
    resetIn = 1'b1;
    #1;
    chk("rst_rdy", reqReady, 1);
    chk("rst_resp", respValid, 0);
    chk("rst_instr", respInstr, 0);
    chk("rst_memreq", memReqValid, 0);
    chk("rst_memaddr", memReqAddr, 0);
    chk("rst_hits", hitCount, 0);
    chk("rst_miss", missCount, 0);
    @(negedge clk);

    // cold miss then same-line hit
    fetch(32'h0000_1008, 0, 0, 0);
    chk("cold_instr", respInstr, 32'h33);
    chk("cold_miss", missCount, 1);
    fetch(32'h0000_100C, 0, 0, 0);
    chk("rep_hit", last_obs_hit, 1);
    chk("rep_instr", respInstr, 32'h44);
    chk("rep_hitcnt", hitCount, 1);

    // 2-way conflict: A, B, touch A, C evicts B
    do_flush();
    fetch(32'h0000_0000, 0, 0, 0);
    fetch(32'h0000_0400, 0, 0, 0);
    fetch(32'h0000_0004, 0, 0, 0);
    chk("touch_a_hit", last_obs_hit, 1);
    fetch(32'h0000_0800, 0, 0, 0);
    chk("c_miss", last_obs_hit, 0);
    fetch(32'h0000_0008, 0, 0, 0);
    chk("a_kept", last_obs_hit, 1);
    fetch(32'h0000_040C, 0, 0, 0);
    chk("b_evicted", last_obs_hit, 0);

    // flush in IDLE with a request, then flush during refill
    flush_req(32'h0000_0000);
    chk("flush_req_miss", last_obs_hit, 0);
    do_flush();
    fetch(32'h0000_5550, 1, 2, 1);
    fetch(32'h0000_5554, 0, 0, 0);
    chk("flush_wait_miss", last_obs_hit, 0);

    // stalled handshake and a stray memRespValid in IDLE
    fetch(32'h0000_7770, 5, 1, 0);
    spurious();
    fetch(32'h0000_7774, 0, 0, 0);
    chk("after_spur_hit", last_obs_hit, 1);

    // direct-mapped instance: B evicts A
    fetch1(32'h0000_0004, 0, "w1_a");
    fetch1(32'h0000_0400, 0, "w1_b");
    fetch1(32'h0000_0008, 0, "w1_a2");
    fetch1(32'h0000_000C, 1, "w1_a3");
    chk("w1_miss_cnt", missCount_1, 3);
    chk("w1_hit_cnt", hitCount_1, 1);

    // reset while the refill data is arriving
    a = 32'h0000_3010;
    reqValid = 1'b1; reqAddr = a;
    @(negedge clk);
    reqValid = 1'b0; memReqReady = 1'b1;
    @(negedge clk);
    memReqReady = 1'b0; memRespValid = 1'b1; memRespData = line_data(a[31:4]);
    #2 resetIn = 1'b0;
    #1;
    chk("mrst_resp", respValid, 0);
    chk("mrst_instr", respInstr, 0);
    chk("mrst_memreq", memReqValid, 0);
    chk("mrst_memaddr", memReqAddr, 0);
    chk("mrst_hits", hitCount, 0);
    chk("mrst_miss", missCount, 0);
    @(negedge clk);
    memRespValid = 1'b0;
    resetIn = 1'b1;
    m_clear(); m_hits = 0; m_miss = 0;
    @(negedge clk);
    fetch(a, 0, 0, 0);
    chk("mrst_refetch_miss", last_obs_hit, 0);
    chk("mrst_miss_cnt", missCount, 1);

    // randomized traffic over a small, conflict-heavy address pool
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2)
         | $urandom_range(0, 3);
      op = $urandom_range(0, 19);
      if (op == 0)      flush_req(a);
      else if (op == 1) spurious();
      else              fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15) == 0);
    end
    chk("final_hits", hitCount, m_hits);
    chk("final_miss", missCount, m_miss);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
